// File: rtl/mnist_uart_pkg.sv
// Shared definitions for the MNIST UART framing path (RX parser and TX formatter):
// frame layout defaults, parser FSM state encoding and per-frame error codes.
package mnist_uart_pkg;

   localparam int unsigned N_PIXELS_DEF    = 784;      // 28x28 payload bytes
   localparam logic [7:0]  SYNC0_DEF       = 8'hAA;
   localparam logic [7:0]  SYNC1_DEF       = 8'h55;
   localparam int unsigned TIMEOUT_CYC_DEF = 50_000;   // 1 ms at 50 MHz

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SYNC1   = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_CHKSUM  = 2'd3
   } rx_state_e;

   typedef enum logic [1:0] {
      ERR_OK      = 2'd0,
      ERR_CSUM    = 2'd1,
      ERR_TIMEOUT = 2'd2
   } frame_err_e;

endpackage

// File: rtl/byte_gap_timer.sv
// Inter-byte gap timer: counts cycles while enabled, cleared by every received byte.
// Saturates at TIMEOUT_CYC-1; 'expired' pulses in the cycle the count steps onto
// TIMEOUT_CYC-1, so a registered consumer reacts TIMEOUT_CYC cycles after the last byte.
module byte_gap_timer
   import mnist_uart_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned      TMR_W    = $clog2(TIMEOUT_CYC);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [TMR_W-1:0] TMR_PRE  = TMR_W'(TIMEOUT_CYC - 2);

   logic [TMR_W-1:0] timer_q;
   logic [TMR_W-1:0] timer_d;

   // Next count: a byte (or leaving the busy states) restarts the gap; otherwise count and saturate.
   always_comb begin
      timer_d = timer_q;
      expired = 1'b0;
      if (clear || !enable) begin
         timer_d = '0;
      end else begin
         if (timer_q != TMR_LAST) begin
            timer_d = timer_q + TMR_W'(1);
         end
         expired = (timer_q == TMR_PRE);
      end
   end

   // Gap counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

endmodule

// File: rtl/mnist_frame_rx_parser.sv
// Receive-side framer between uart_rx and mnist_network_core: hunts the two-byte sync
// header, forwards N_PIXELS payload bytes cut-through as a pixel stream, verifies the
// trailing mod-256 checksum and reports a per-frame status (OK / bad checksum / timeout).
module mnist_frame_rx_parser
   import mnist_uart_pkg::*;
#(
   parameter int unsigned N_PIXELS    = N_PIXELS_DEF,
   parameter logic [7:0]  SYNC0       = SYNC0_DEF,
   parameter logic [7:0]  SYNC1       = SYNC1_DEF,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   output logic [7:0] pixel_out,
   output logic       pixel_valid,
   output logic       frame_start,
   output logic       frame_done,
   output logic [1:0] frame_err,
   output logic       busy
);

   localparam int unsigned      CNT_W    = $clog2(N_PIXELS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PIXELS - 1);

   rx_state_e        state_q,       state_d;
   logic [CNT_W-1:0] cnt_q,         cnt_d;
   logic [7:0]       sum_q,         sum_d;
   logic [7:0]       pixel_out_q,   pixel_out_d;
   logic             pixel_valid_q, pixel_valid_d;
   logic             frame_start_q, frame_start_d;
   logic             frame_done_q,  frame_done_d;
   frame_err_e       frame_err_q,   frame_err_d;
   logic             busy_q,        busy_d;
   logic             gap_expired;

   byte_gap_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_gap_timer (
      .clk     (sys_clk),
      .rst_n   (sys_rst_n),
      .clear   (rx_valid),
      .enable  (busy_q),
      .expired (gap_expired)
   );

   // Frame FSM next-state and output decode; a received byte always takes priority over a timeout.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      sum_d         = sum_q;
      pixel_out_d   = pixel_out_q;
      pixel_valid_d = 1'b0;
      frame_start_d = 1'b0;
      frame_done_d  = 1'b0;
      frame_err_d   = frame_err_q;
      if (rx_valid) begin
         unique case (state_q)
            ST_IDLE: begin
               if (rx_byte == SYNC0) begin
                  state_d = ST_SYNC1;
               end
            end
            ST_SYNC1: begin
               if (rx_byte == SYNC1) begin
                  state_d       = ST_PAYLOAD;
                  frame_start_d = 1'b1;
                  cnt_d         = '0;
                  sum_d         = '0;
               end else if (rx_byte != SYNC0) begin
                  state_d = ST_IDLE;
               end
            end
            ST_PAYLOAD: begin
               pixel_out_d   = rx_byte;
               pixel_valid_d = 1'b1;
               sum_d         = sum_q + rx_byte;
               cnt_d         = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_CHKSUM;
               end
            end
            ST_CHKSUM: begin
               frame_err_d  = (rx_byte == sum_q) ? ERR_OK : ERR_CSUM;
               frame_done_d = 1'b1;
               state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (gap_expired) begin
         unique case (state_q)
            ST_SYNC1: state_d = ST_IDLE;
            ST_PAYLOAD, ST_CHKSUM: begin
               frame_err_d  = ERR_TIMEOUT;
               frame_done_d = 1'b1;
               state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      busy_d = (state_d != ST_IDLE);
   end

   // State, datapath and registered outputs; reset abandons any frame without a done pulse.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         sum_q         <= '0;
         pixel_out_q   <= '0;
         pixel_valid_q <= 1'b0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_err_q   <= ERR_OK;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         sum_q         <= sum_d;
         pixel_out_q   <= pixel_out_d;
         pixel_valid_q <= pixel_valid_d;
         frame_start_q <= frame_start_d;
         frame_done_q  <= frame_done_d;
         frame_err_q   <= frame_err_d;
         busy_q        <= busy_d;
      end
   end

   assign pixel_out   = pixel_out_q;
   assign pixel_valid = pixel_valid_q;
   assign frame_start = frame_start_q;
   assign frame_done  = frame_done_q;
   assign frame_err   = frame_err_q;
   assign busy        = busy_q;

endmodule
